shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Sequences the operand-2 barrel-shift step of a data-processing instruction. Accepts a decoded operand-2 field plus Rm value and carry flag. For register-specified shifts it fetches Rs through a shared register-file read port. It returns the shifted operand and the ARM-exact shifter carry-out to the ALU stage over a valid/ready handshake.

## Interface
- no parameters; data width fixed at 32, register index width 4
- `clk` in 1: sole clock
- `reset` in 1: synchronous, active-high
- `flush` in 1: synchronous abort of any in-flight operation (branch/exception)
- `in_valid` in 1: request valid
- `in_ready` out 1: block can accept a request
- `imm` in 1: I bit; 1 = rotated 8-bit immediate
- `op2` in 12: instr[11:0]
- `rm_val` in 32: value of Rm (ignored when imm=1)
- `carry_in` in 1: current CPSR C
- `rs_req` out 1: request for shared register-file read port
- `rs_addr` out 4: Rs index, = op2[11:8] of accepted request
- `rs_gnt` in 1: port granted this cycle; `rs_data` valid same cycle
- `rs_data` in 32: Rs value
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `y` out 32: shifted operand
- `c` out 1: shifter carry-out

## Operation
- Request decode (latched on `in_valid && in_ready`):
  - imm=1: rotated immediate
  - imm=0, op2[4]=0: immediate shift (amount op2[11:7], type op2[6:5])
  - imm=0, op2[4]=1: register shift (Rs=op2[11:8], type op2[6:5], amount = rs_data[7:0])
- States:
  - IDLE: in_ready=1. On accept, immediate/imm-shift -> RESULT; register shift -> FETCH.
  - FETCH: rs_req=1, rs_addr held. On rs_gnt, latch rs_data[7:0] -> RESULT. Waits indefinitely without grant.
  - RESULT: out_valid=1; y/c stable. On out_ready -> IDLE.
- Rotated immediate: rot = 2*op2[11:8]; y = ROR(op2[7:0], rot); c = carry_in if rot==0 else y[31].
- Immediate shift, amount n=op2[11:7]:
  - LSL: n=0 -> y=Rm, c=C; else y=Rm<<n, c=Rm[32-n].
  - LSR: n=0 means 32 -> y=0, c=Rm[31]; else y=Rm>>n, c=Rm[n-1].
  - ASR: n=0 means 32 -> y = 32 copies of Rm[31], c=Rm[31]; else arithmetic shift, c=Rm[n-1].
  - ROR: n=0 means RRX -> y={C,Rm[31:1]}, c=Rm[0]; else rotate, c=Rm[n-1].
- Register shift, s=rs_data[7:0] (upper 24 bits ignored); s=0 -> y=Rm, c=C for every type:
  - LSL: s<32 normal; s=32 -> y=0, c=Rm[0]; s>32 -> y=0, c=0.
  - LSR: s<32 normal; s=32 -> y=0, c=Rm[31]; s>32 -> y=0, c=0.
  - ASR: s>=32 -> y=sign fill, c=Rm[31].
  - ROR: s[4:0]=0 -> y=Rm, c=Rm[31]; else rotate by s[4:0], c=Rm[s[4:0]-1].
- Result computed from registered request fields. Rm and C are sampled at accept; later changes are ignored.
- flush: any state -> IDLE next cycle. rs_req and out_valid drop next cycle. A pending result is discarded. A request presented in the same cycle as flush is not accepted.
- reset overrides flush.

## Timing
- After reset: state IDLE, in_ready=1, rs_req=0, rs_addr=0, out_valid=0, y=0, c=0.
- Immediate/imm-shift: accepted cycle N -> out_valid at N+1.
- Register shift: accepted N; rs_req from N+1; grant at cycle G -> out_valid at G+1. Earliest is N+2.
- out_valid with out_ready=0: y, c, out_valid held unchanged.
- Throughput: one result per 2 cycles minimum. No accept while out_valid=1 (in_ready=0 outside IDLE).
- Result is registered; the rs_data-to-y path does not exist combinationally.

## Structure
- `shift_pkg`: `shift_type_e` (LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11), `seq_state_e` (IDLE, FETCH, RESULT), width constants.
- Sub-module `shift_carry_core`: combinational (type, amount[7:0], is_imm_shift, Rm, C) -> (y, c) implementing all rules above. It is instantiated once, and a separate small rotator handles the immediate path.
- FSM, request registers and result registers live in the top.

## Test plan
- imm=1, op2=0x4FF, C=0 -> y=0xFF000000, c=1, out_valid one cycle after accept.
- imm=0, op2=0x020 (LSR #0), Rm=0x80000001 -> y=0, c=1. Then op2=0x060 (RRX), Rm=0x3, C=1 -> y=0x80000001, c=1.
- Register LSL, rs_data=0x20, Rm=0x1 -> y=0, c=1. rs_data=0x21 -> y=0, c=0. rs_data=0xFFFFFF00 -> y=Rm, c=C.
- Register ROR, rs_data=0x20, Rm=0x80000000 -> y=0x80000000, c=1. rs_gnt delayed 3 cycles -> rs_req held, out_valid exactly 1 cycle after grant.
- out_ready low 4 cycles in RESULT -> y, c stable, in_ready=0; accept resumes the cycle after the handshake.
- flush in FETCH and in RESULT -> next cycle IDLE, rs_req=0, out_valid=0. reset mid-FETCH -> all outputs at reset values.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types, widths and immediate rotator for the shift sequencer
//
// Purpose: shift type and sequencer state encodings, data/register widths,
// and the rotated-immediate helper used by the top for the I=1 path.
// Ports: none (package).

package shift_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    RESULT = 2'b10
  } seq_state_e;

  // Rotated 8-bit immediate: ROR(op2[7:0], 2*op2[11:8]).
  // Returns {carry, value}; a zero rotation passes the incoming carry through.
  function automatic logic [32:0] rotate_imm(input logic [11:0] op2, input logic cin);
    logic [4:0]  rot;
    logic [31:0] v;
    logic [31:0] r;
    rot = {op2[11:8], 1'b0};
    v   = {24'b0, op2[7:0]};
    r   = (v >> rot) | (v << (5'd0 - rot));
    return {((rot == 5'd0) ? cin : r[31]), r};
  endfunction

endpackage

// File: rtl/shift_carry_core.sv
// rtl/shift_carry_core.sv - combinational barrel shifter with ARM shifter carry-out
//
// Purpose: applies LSL/LSR/ASR/ROR to rm for both the immediate-amount and the
// register-amount encodings, including the amount-0 and amount>=32 special cases.
// Ports:
//   shift_type    in  2   shift kind (shift_type_e)
//   amount        in  8   shift amount (imm shift: 0..31 in [4:0]; reg shift: Rs[7:0])
//   is_imm_shift  in  1   1 = amount came from the instruction, 0 = from Rs
//   rm            in  32  operand to shift
//   cin           in  1   current carry flag
//   y             out 32  shifted operand
//   c             out 1   shifter carry-out

import shift_pkg::*;

module shift_carry_core (
  input  shift_type_e shift_type,
  input  logic [7:0]  amount,
  input  logic        is_imm_shift,
  input  logic [31:0] rm,
  input  logic        cin,
  output logic [31:0] y,
  output logic        c
);

  logic [4:0]  n;
  logic        big;       // register amount >= 32
  logic        is32;
  logic [31:0] lsl_y;
  logic [31:0] lsr_y;
  logic [31:0] asr_y;
  logic [31:0] ror_y;
  logic        c_lsl;     // last bit shifted out on the left, valid for n in 1..31
  logic        c_right;   // last bit shifted out on the right, valid for n in 1..31

  assign n       = amount[4:0];
  assign big     = |amount[7:5];
  assign is32    = (amount == 8'd32);
  assign lsl_y   = rm << n;
  assign lsr_y   = rm >> n;
  assign asr_y   = $signed(rm) >>> n;
  assign ror_y   = (rm >> n) | (rm << (5'd0 - n));
  assign c_lsl   = rm[5'd0 - n];
  assign c_right = rm[n - 5'd1];

  always_comb begin
    y = rm;
    c = cin;
    if (is_imm_shift) begin
      // An encoded amount of 0 means: LSL #0 (pass), LSR/ASR #32, or RRX.
      case (shift_type)
        LSL: begin
          if (n != 5'd0) begin
            y = lsl_y;
            c = c_lsl;
          end
        end
        LSR: begin
          if (n == 5'd0) begin
            y = 32'b0;
            c = rm[31];
          end else begin
            y = lsr_y;
            c = c_right;
          end
        end
        ASR: begin
          if (n == 5'd0) begin
            y = {32{rm[31]}};
            c = rm[31];
          end else begin
            y = asr_y;
            c = c_right;
          end
        end
        default: begin
          if (n == 5'd0) begin
            y = {cin, rm[31:1]};
            c = rm[0];
          end else begin
            y = ror_y;
            c = c_right;
          end
        end
      endcase
    end else if (amount != 8'd0) begin
      case (shift_type)
        LSL: begin
          if (big) begin
            y = 32'b0;
            c = is32 ? rm[0] : 1'b0;
          end else begin
            y = lsl_y;
            c = c_lsl;
          end
        end
        LSR: begin
          if (big) begin
            y = 32'b0;
            c = is32 ? rm[31] : 1'b0;
          end else begin
            y = lsr_y;
            c = c_right;
          end
        end
        ASR: begin
          if (big) begin
            y = {32{rm[31]}};
            c = rm[31];
          end else begin
            y = asr_y;
            c = c_right;
          end
        end
        default: begin
          // Rotation is modulo 32; a multiple of 32 leaves rm intact but
          // still reports bit 31 as the carry.
          if (n == 5'd0) begin
            y = rm;
            c = rm[31];
          end else begin
            y = ror_y;
            c = c_right;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - operand-2 shift sequencer with Rs fetch and result handshake
//
// Purpose: accepts a decoded operand-2 request, fetches Rs through the shared
// register-file port for register-specified shifts, and presents the shifted
// operand and shifter carry-out to the ALU stage.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             abort any in-flight operation
//   in_valid/in_ready request handshake
//   imm, op2, rm_val, carry_in   request fields (sampled at accept)
//   rs_req, rs_addr   register-file read request and index
//   rs_gnt, rs_data   register-file grant and data (same cycle)
//   out_valid/out_ready result handshake
//   y, c              shifted operand and carry-out

import shift_pkg::*;

module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        imm,
  input  logic [11:0] op2,
  input  logic [31:0] rm_val,
  input  logic        carry_in,
  output logic        rs_req,
  output logic [3:0]  rs_addr,
  input  logic        rs_gnt,
  input  logic [31:0] rs_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        c
);

  seq_state_e  state;
  seq_state_e  state_next;

  logic        req_imm;
  logic [11:0] req_op2;
  logic [31:0] req_rm;
  logic        req_c;
  logic [7:0]  req_amt;

  logic        accept;
  logic        reg_shift_in;
  logic [32:0] rot_res;
  logic [31:0] core_y;
  logic        core_c;
  logic [7:0]  core_amount;
  logic        unused_rs_hi;

  // Only the low byte of Rs is a shift amount.
  assign unused_rs_hi = ^rs_data[31:8];

  assign in_ready     = (state == IDLE);
  assign accept       = in_valid && in_ready && !flush;
  assign reg_shift_in = !imm && op2[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_imm <= 1'b0;
      req_op2 <= '0;
      req_rm  <= '0;
      req_c   <= 1'b0;
      req_amt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_imm <= imm;
        req_op2 <= op2;
        req_rm  <= rm_val;
        req_c   <= carry_in;
      end
      if (state == FETCH && rs_gnt && !flush) begin
        req_amt <= rs_data[7:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = reg_shift_in ? FETCH : RESULT;
      FETCH:   if (rs_gnt) state_next = RESULT;
      RESULT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  assign rs_req    = (state == FETCH);
  assign rs_addr   = req_op2[11:8];
  assign out_valid = (state == RESULT);

  // The result is a pure function of the request registers, so it is stable
  // for as long as they are held; with all registers cleared it reads as 0/0.
  assign core_amount = req_op2[4] ? req_amt : {3'b0, req_op2[11:7]};
  assign rot_res     = rotate_imm(req_op2, req_c);

  shift_carry_core u_core (
    .shift_type   (shift_type_e'(req_op2[6:5])),
    .amount       (core_amount),
    .is_imm_shift (!req_op2[4]),
    .rm           (req_rm),
    .cin          (req_c),
    .y            (core_y),
    .c            (core_c)
  );

  assign y = req_imm ? rot_res[31:0] : core_y;
  assign c = req_imm ? rot_res[32]   : core_c;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer

module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        imm;
  logic [11:0] op2;
  logic [31:0] rm_val;
  logic        carry_in;
  logic        rs_req;
  logic [3:0]  rs_addr;
  logic        rs_gnt;
  logic [31:0] rs_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        c;

  int checks = 0;
  int errors = 0;

  logic        armed = 1'b0;
  logic [31:0] exp_y = '0;
  logic        exp_c = 1'b0;

  shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .op2       (op2),
    .rm_val    (rm_val),
    .carry_in  (carry_in),
    .rs_req    (rs_req),
    .rs_addr   (rs_addr),
    .rs_gnt    (rs_gnt),
    .rs_data   (rs_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: shift one bit at a time, carry = last bit shifted out.
  function automatic logic [32:0] model(input logic i_imm, input logic [11:0] i_op2,
                                        input logic [31:0] i_rm, input logic i_c,
                                        input logic [7:0] rs8);
    logic [31:0] v;
    logic        cc;
    int          k;
    logic [1:0]  t;
    cc = i_c;
    if (i_imm) begin
      v = {24'b0, i_op2[7:0]};
      k = 2 * int'(i_op2[11:8]);
      for (int i = 0; i < k; i++) begin
        cc = v[0];
        v  = {v[0], v[31:1]};
      end
      return {cc, v};
    end
    t = i_op2[6:5];
    v = i_rm;
    if (!i_op2[4]) begin
      k = int'(i_op2[11:7]);
      if (k == 0) begin
        if (t == 2'd1 || t == 2'd2) k = 32;
        if (t == 2'd3) return {i_rm[0], i_c, i_rm[31:1]};
      end
    end else begin
      k = int'(rs8);
    end
    for (int i = 0; i < k; i++) begin
      case (t)
        2'd0: begin cc = v[31]; v = v << 1; end
        2'd1: begin cc = v[0];  v = v >> 1; end
        2'd2: begin cc = v[0];  v = {v[31], v[31:1]}; end
        default: begin cc = v[0]; v = {v[0], v[31:1]}; end
      endcase
    end
    return {cc, v};
  endfunction

  // Compare process: every cycle a result is presented, it must match the model.
  always @(negedge clk) begin
    if (armed && out_valid) begin
      check("result_y", 64'(y), 64'(exp_y));
      check("result_c", 64'(c), 64'(exp_c));
    end
  end

  task automatic run_req(input logic i_imm, input logic [11:0] i_op2, input logic [31:0] i_rm,
                         input logic i_c, input logic [31:0] i_rs, input int gnt_delay,
                         input int rdy_delay);
    logic [32:0] m;
    logic        is_reg;
    is_reg   = !i_imm && i_op2[4];
    m        = model(i_imm, i_op2, i_rm, i_c, i_rs[7:0]);
    in_valid = 1'b1;
    imm      = i_imm;
    op2      = i_op2;
    rm_val   = i_rm;
    carry_in = i_c;
    #1;
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    imm      = 1'($urandom);
    op2      = 12'($urandom);
    rm_val   = $urandom;
    carry_in = ~i_c;
    exp_y    = m[31:0];
    exp_c    = m[32];
    armed    = 1'b1;
    if (is_reg) begin
      for (int d = 0; d < gnt_delay; d++) begin
        @(negedge clk);
        check("fetch_rs_req", 64'(rs_req), 64'd1);
        check("fetch_rs_addr", 64'(rs_addr), 64'(i_op2[11:8]));
        check("fetch_out_valid", 64'(out_valid), 64'd0);
        check("fetch_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
      end
      rs_gnt  = 1'b1;
      rs_data = i_rs;
      @(negedge clk);
      check("grant_rs_req", 64'(rs_req), 64'd1);
      check("grant_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      rs_gnt  = 1'b0;
      rs_data = $urandom;
    end
    for (int d = 0; d < rdy_delay; d++) begin
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_rs_req", 64'(rs_req), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("handshake_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    armed     = 1'b0;
    @(negedge clk);
    check("after_out_valid", 64'(out_valid), 64'd0);
    check("after_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_rs_req"}, 64'(rs_req), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    imm       = 1'b0;
    op2       = '0;
    rm_val    = '0;
    carry_in  = 1'b0;
    rs_gnt    = 1'b0;
    rs_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_rs_addr", 64'(rs_addr), 64'd0);
    check("reset_y", 64'(y), 64'd0);
    check("reset_c", 64'(c), 64'd0);

    // Pin the model on hand-computed values.
    check("pin_rot_imm", 64'(model(1'b1, 12'h4FF, 32'h0, 1'b0, 8'h0)), 64'h1_FF00_0000);
    check("pin_lsr0", 64'(model(1'b0, 12'h020, 32'h8000_0001, 1'b0, 8'h0)), 64'h1_0000_0000);
    check("pin_rrx", 64'(model(1'b0, 12'h060, 32'h3, 1'b1, 8'h0)), 64'h1_8000_0001);
    check("pin_lsl32", 64'(model(1'b0, 12'h310, 32'h1, 1'b0, 8'h20)), 64'h1_0000_0000);
    check("pin_lsl33", 64'(model(1'b0, 12'h310, 32'h1, 1'b1, 8'h21)), 64'h0_0000_0000);
    check("pin_reg0", 64'(model(1'b0, 12'h310, 32'h1, 1'b1, 8'h00)), 64'h1_0000_0001);
    check("pin_ror32", 64'(model(1'b0, 12'h570, 32'h8000_0000, 1'b0, 8'h20)), 64'h1_8000_0000);
    check("pin_lsl4", 64'(model(1'b0, 12'h200, 32'h1234_5678, 1'b0, 8'h0)), 64'h1_2345_6780);
    check("pin_rot2", 64'(model(1'b1, 12'h1AB, 32'h0, 1'b0, 8'h0)), 64'h1_C000_002A);

    // Directed transactions: (imm, op2, rm, C, rs_data, grant delay, ready delay).
    @(posedge clk); #1;
    run_req(1'b1, 12'h4FF, 32'h0,         1'b0, 32'h0,        0, 0);
    run_req(1'b0, 12'h020, 32'h8000_0001, 1'b0, 32'h0,        0, 0);
    run_req(1'b0, 12'h060, 32'h0000_0003, 1'b1, 32'h0,        0, 0);
    run_req(1'b0, 12'h310, 32'h0000_0001, 1'b0, 32'h20,       0, 0);
    run_req(1'b0, 12'h310, 32'h0000_0001, 1'b1, 32'h21,       0, 1);
    run_req(1'b0, 12'h310, 32'h0000_0001, 1'b1, 32'hFFFF_FF00, 1, 0);
    run_req(1'b0, 12'h570, 32'h8000_0000, 1'b0, 32'h20,       3, 0);
    run_req(1'b1, 12'h1AB, 32'hFFFF_FFFF, 1'b0, 32'h0,        0, 4);
    run_req(1'b0, 12'h200, 32'h1234_5678, 1'b0, 32'h0,        0, 0);
    run_req(1'b0, 12'h040, 32'h8000_0000, 1'b0, 32'h0,        0, 0);
    run_req(1'b0, 12'h230, 32'h0000_00F0, 1'b1, 32'h4,        2, 0);
    run_req(1'b0, 12'h150, 32'h7FFF_FFFF, 1'b1, 32'h28,       0, 2);
    run_req(1'b0, 12'h370, 32'hA5A5_0F0F, 1'b0, 32'h107,      1, 0);

    // Flush during FETCH, with a grant arriving the same cycle.
    in_valid = 1'b1; imm = 1'b0; op2 = 12'h310; rm_val = 32'h5; carry_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_fetch_pre_rs_req", 64'(rs_req), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1; rs_gnt = 1'b1; rs_data = 32'h1;
    @(posedge clk); #1;
    flush = 1'b0; rs_gnt = 1'b0;
    @(negedge clk);
    check_idle("flush_fetch");
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("flush_fetch_late");

    // Flush during RESULT discards the pending result.
    in_valid = 1'b1; imm = 1'b1; op2 = 12'h4FF; carry_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_result_pre_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_idle("flush_result");

    // A request alongside flush is not accepted.
    in_valid = 1'b1; imm = 1'b1; op2 = 12'h0FF; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_idle("flush_with_req");

    // Reset in the middle of FETCH.
    in_valid = 1'b1; imm = 1'b0; op2 = 12'hF30; rm_val = 32'hDEAD_BEEF; carry_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_fetch_pre_addr", 64'(rs_addr), 64'hF);
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_idle("reset_fetch");
    check("reset_fetch_rs_addr", 64'(rs_addr), 64'd0);
    check("reset_fetch_y", 64'(y), 64'd0);
    check("reset_fetch_c", 64'(c), 64'd0);

    // Normal operation resumes after reset.
    @(posedge clk); #1;
    run_req(1'b0, 12'h310, 32'h0000_0001, 1'b0, 32'h3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
